// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - Pipeline-side signal bundle of the hazard controller
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_fence;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_stall;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             redirect_vld;
    logic [31:0]      redirect_pc;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_fence,
               ex_rd, ex_memread, ex_taken, ex_target, mem_req, mem_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_flush, redirect_vld, redirect_pc,
               mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_fence,
               ex_rd, ex_memread, ex_taken, ex_target, mem_req, mem_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_flush, redirect_vld, redirect_pc,
               mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic             mem_err_q, mem_err_d;
    logic             fence_done_q, fence_done_d;
    logic             lu_q, lu_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic exmem_stall, exmem_flush, memwb_flush, redirect_vld;
    logic mem_miss, load_use, fence_drained;

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        dcnt_d        = dcnt_q;
        mem_err_d     = 1'b0;
        lu_d          = 1'b0;
        fence_drained = 1'b0;
        pc_stall      = 1'b0;
        ifid_stall    = 1'b0;
        ifid_flush    = 1'b0;
        idex_stall    = 1'b0;
        idex_flush    = 1'b0;
        exmem_stall   = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        redirect_vld  = 1'b0;
        mem_miss      = hz.mem_req & ~hz.mem_ready;
        load_use      = hz.ex_memread & (hz.ex_rd != 5'd0) &
                        ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                         (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

        // A miss during DRAIN also freezes the pipe; the FENCE stays in ID and re-drains later.
        if (state_q == S_MEM_WAIT || mem_miss) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
            if (state_q != S_MEM_WAIT) begin
                state_d = S_MEM_WAIT;
                wcnt_d  = 8'd0;
            end else if (hz.mem_ready) begin
                state_d = S_RUN;
            end else if (wcnt_q == WAIT_LAST) begin
                state_d     = S_RUN;
                mem_err_d   = 1'b1;
                exmem_stall = 1'b0;
                exmem_flush = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 8'd1;
            end
        end else if (hz.ex_taken) begin
            redirect_vld = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            state_d      = S_RUN;
        end else if (state_q == S_DRAIN) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            dcnt_d     = dcnt_q - 4'd1;
            if (dcnt_q == 4'd1) begin
                state_d       = S_RUN;
                fence_drained = 1'b1;
            end
        end else if (hz.id_fence && !fence_done_q) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            dcnt_d     = DRAIN_LOAD;
            if (DRAIN_LOAD == 4'd0) begin
                fence_drained = 1'b1;
            end else begin
                state_d = S_DRAIN;
            end
        end else if (load_use && !lu_q) begin
            // The load moves on during this bubble, so a second stall would be spurious.
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            lu_d       = 1'b1;
        end

        // A drained FENCE must not retrigger while it is still held in ID.
        fence_done_d = fence_drained | (fence_done_q & ifid_stall);

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (ifid_flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            wcnt_q       <= 8'd0;
            dcnt_q       <= 4'd0;
            mem_err_q    <= 1'b0;
            fence_done_q <= 1'b0;
            lu_q         <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            dcnt_q       <= dcnt_d;
            mem_err_q    <= mem_err_d;
            fence_done_q <= fence_done_d;
            lu_q         <= lu_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hz.pc_stall     = pc_stall & ~rst;
    assign hz.ifid_stall   = ifid_stall & ~rst;
    assign hz.ifid_flush   = ifid_flush & ~rst;
    assign hz.idex_stall   = idex_stall & ~rst;
    assign hz.idex_flush   = idex_flush & ~rst;
    assign hz.exmem_stall  = exmem_stall & ~rst;
    assign hz.exmem_flush  = exmem_flush & ~rst;
    assign hz.memwb_flush  = memwb_flush & ~rst;
    assign hz.redirect_vld = redirect_vld & ~rst;
    assign hz.redirect_pc  = hz.ex_target;
    assign hz.mem_err      = mem_err_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - Self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int DRAIN_A = 2;
    localparam int TO_A    = 4;
    localparam int CNT_A   = 16;
    localparam int DRAIN_B = 4;
    localparam int CNT_B   = 4;
    localparam int SAT_A   = (1 << CNT_A) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, id_fence, ex_memread, ex_taken, mem_req, mem_ready;
    logic [31:0] ex_target;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_A)) ifa ();
    pipe_hazard_ctrl_if #(.CNT_W(CNT_B)) ifb ();

    assign ifa.id_rs1 = id_rs1;         assign ifb.id_rs1 = id_rs1;
    assign ifa.id_rs2 = id_rs2;         assign ifb.id_rs2 = id_rs2;
    assign ifa.id_use_rs1 = id_use_rs1; assign ifb.id_use_rs1 = id_use_rs1;
    assign ifa.id_use_rs2 = id_use_rs2; assign ifb.id_use_rs2 = id_use_rs2;
    assign ifa.id_fence = id_fence;     assign ifb.id_fence = id_fence;
    assign ifa.ex_rd = ex_rd;           assign ifb.ex_rd = ex_rd;
    assign ifa.ex_memread = ex_memread; assign ifb.ex_memread = ex_memread;
    assign ifa.ex_taken = ex_taken;     assign ifb.ex_taken = ex_taken;
    assign ifa.ex_target = ex_target;   assign ifb.ex_target = ex_target;
    assign ifa.mem_req = mem_req;       assign ifb.mem_req = mem_req;
    assign ifa.mem_ready = mem_ready;   assign ifb.mem_ready = mem_ready;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_A), .MEM_TIMEOUT(TO_A), .CNT_W(CNT_A)) dut_a (
        .clk(clk), .rst(rst), .hz(ifa)
    );
    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_B), .MEM_TIMEOUT(TO_A), .CNT_W(CNT_B)) dut_b (
        .clk(clk), .rst(rst), .hz(ifb)
    );

    // bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall exmem_flush memwb_flush redirect_vld
    logic [8:0] ctrl_a, ctrl_b;
    assign ctrl_a = {ifa.pc_stall, ifa.ifid_stall, ifa.ifid_flush, ifa.idex_stall, ifa.idex_flush,
                     ifa.exmem_stall, ifa.exmem_flush, ifa.memwb_flush, ifa.redirect_vld};
    assign ctrl_b = {ifb.pc_stall, ifb.ifid_stall, ifb.ifid_flush, ifb.idex_stall, ifb.idex_flush,
                     ifb.exmem_stall, ifb.exmem_flush, ifb.memwb_flush, ifb.redirect_vld};

    localparam logic [8:0] V_NONE  = 9'b000000000;
    localparam logic [8:0] V_BUBL  = 9'b110010000;
    localparam logic [8:0] V_REDIR = 9'b001010001;
    localparam logic [8:0] V_MWAIT = 9'b110101010;
    localparam logic [8:0] V_ABORT = 9'b110100110;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: wait = memory cycles already waited (-1 when not waiting),
    // drain = drain cycles still owed, drained = FENCE in ID already served.
    int   m_wait, m_drain, m_scnt, m_fcnt;
    bit   m_drained, m_lu, m_err;
    int   nx_wait, nx_drain;
    bit   nx_drained, nx_lu, nx_err;
    logic [8:0] exp_ctrl;

    task automatic model_reset();
        m_wait = -1; m_drain = 0; m_scnt = 0; m_fcnt = 0;
        m_drained = 0; m_lu = 0; m_err = 0;
    endtask

    task automatic model_eval();
        bit hazard, served;
        hazard = ex_memread && ex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        exp_ctrl = V_NONE;
        nx_wait = -1; nx_drain = 0; nx_lu = 0; nx_err = 0; served = 0;
        if (m_wait >= 0 || (mem_req && !mem_ready)) begin
            exp_ctrl = V_MWAIT;
            if (m_wait < 0) nx_wait = 0;
            else if (!mem_ready) begin
                if (m_wait + 1 == TO_A) begin exp_ctrl = V_ABORT; nx_err = 1; end
                else nx_wait = m_wait + 1;
            end
        end else if (ex_taken) begin
            exp_ctrl = V_REDIR;
        end else if (m_drain > 0) begin
            exp_ctrl = V_BUBL;
            nx_drain = m_drain - 1;
            served = (nx_drain == 0);
        end else if (id_fence && !m_drained) begin
            exp_ctrl = V_BUBL;
            nx_drain = DRAIN_A - 1;
            served = (nx_drain == 0);
        end else if (hazard && !m_lu) begin
            exp_ctrl = V_BUBL;
            nx_lu = 1;
        end
        nx_drained = served || (m_drained && exp_ctrl[7]);
    endtask

    task automatic model_commit();
        m_wait = nx_wait; m_drain = nx_drain; m_lu = nx_lu; m_err = nx_err; m_drained = nx_drained;
        if (exp_ctrl[8] && m_scnt < SAT_A) m_scnt++;
        if (exp_ctrl[6] && m_fcnt < SAT_A) m_fcnt++;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_fence = 0;
        ex_memread = 0; ex_taken = 0; mem_req = 0; mem_ready = 0; ex_target = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        mem_req = 1; ex_taken = 1; id_fence = 1; ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        @(posedge clk);
        #1;
        n_vec++; if (ctrl_a !== V_NONE) begin n_bad++; $display("FAIL reset_ctrl: got %b want %b", ctrl_a, V_NONE); end
        n_vec++; if (ifa.mem_err !== 1'b0 || ifa.stall_cnt !== 16'd0 || ifa.flush_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_regs: got err=%b stall=%0d flush=%0d want 0 0 0", ifa.mem_err, ifa.stall_cnt, ifa.flush_cnt);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        settle();
        n_vec++; if (ctrl_a !== V_BUBL) begin n_bad++; $display("FAIL lu_stall: got %b want %b", ctrl_a, V_BUBL); end
        advance(); settle();
        n_vec++; if (ctrl_a !== V_NONE) begin n_bad++; $display("FAIL lu_once: got %b want %b", ctrl_a, V_NONE); end
        n_vec++; if (ifa.stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt: got %0d want 1", ifa.stall_cnt); end
        advance();
        ex_rd = 0; id_rs2 = 0;
        settle();
        n_vec++; if (ctrl_a !== V_NONE) begin n_bad++; $display("FAIL lu_x0: got %b want %b", ctrl_a, V_NONE); end
        advance();
    endtask

    task automatic test_branch();
        do_reset();
        ex_taken = 1; ex_target = 32'h0000_0100;
        settle();
        n_vec++; if (ctrl_a !== V_REDIR) begin n_bad++; $display("FAIL br_ctrl: got %b want %b", ctrl_a, V_REDIR); end
        n_vec++; if (ifa.redirect_pc !== 32'h100) begin n_bad++; $display("FAIL br_pc: got %h want 00000100", ifa.redirect_pc); end
        advance();
        ex_taken = 0;
        settle();
        n_vec++; if (ctrl_a !== V_NONE) begin n_bad++; $display("FAIL br_once: got %b want %b", ctrl_a, V_NONE); end
        n_vec++; if (ifa.flush_cnt !== 16'd1) begin n_bad++; $display("FAIL br_cnt: got %0d want 1", ifa.flush_cnt); end
        advance();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; ex_taken = 1; ex_target = 32'h200;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            settle();
            n_vec++; if (ctrl_a !== V_MWAIT) begin n_bad++; $display("FAIL mw_cyc%0d: got %b want %b", i, ctrl_a, V_MWAIT); end
            advance();
        end
        mem_req = 0; mem_ready = 0;
        settle();
        n_vec++; if (ctrl_a !== V_REDIR) begin n_bad++; $display("FAIL mw_release: got %b want %b", ctrl_a, V_REDIR); end
        n_vec++; if (ifa.stall_cnt !== 16'd4) begin n_bad++; $display("FAIL mw_cnt: got %0d want 4", ifa.stall_cnt); end
        advance();
        ex_taken = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1;
        for (int i = 0; i <= TO_A; i++) begin
            settle();
            n_vec++;
            if (ctrl_a !== ((i == TO_A) ? V_ABORT : V_MWAIT) || ifa.mem_err !== 1'b0) begin
                n_bad++; $display("FAIL to_cyc%0d: got %b err=%b", i, ctrl_a, ifa.mem_err);
            end
            advance();
        end
        mem_req = 0;
        settle();
        n_vec++; if (ifa.mem_err !== 1'b1 || ctrl_a !== V_NONE) begin
            n_bad++; $display("FAIL to_err: got err=%b ctrl=%b want 1 %b", ifa.mem_err, ctrl_a, V_NONE);
        end
        advance(); settle();
        n_vec++; if (ifa.mem_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse: got %b want 0", ifa.mem_err); end
        advance();
    endtask

    task automatic test_fence();
        do_reset();
        id_fence = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_vec++; if (ctrl_a !== ((i < DRAIN_A) ? V_BUBL : V_NONE)) begin
                n_bad++; $display("FAIL fence_cyc%0d: got %b want %b", i, ctrl_a, (i < DRAIN_A) ? V_BUBL : V_NONE);
            end
            advance();
        end
        id_fence = 0;
        settle();
        n_vec++; if (ifa.stall_cnt !== 16'd2) begin n_bad++; $display("FAIL fence_cnt: got %0d want 2", ifa.stall_cnt); end
        advance();
        do_reset();
        id_fence = 1;
        settle(); advance();
        ex_taken = 1; ex_target = 32'h40;
        settle();
        n_vec++; if (ctrl_b !== V_REDIR) begin n_bad++; $display("FAIL fence_redir: got %b want %b", ctrl_b, V_REDIR); end
        advance();
        ex_taken = 0; id_fence = 0;
        settle();
        n_vec++; if (ctrl_b !== V_NONE) begin n_bad++; $display("FAIL fence_abort: got %b want %b", ctrl_b, V_NONE); end
        advance();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1;
        settle(); advance(); settle(); advance();
        rst = 1'b1;
        #1;
        n_vec++; if (ctrl_a !== V_NONE || ctrl_b !== V_NONE) begin
            n_bad++; $display("FAIL rmw_ctrl: got %b %b want %b", ctrl_a, ctrl_b, V_NONE);
        end
        n_vec++; if (ifa.stall_cnt !== 16'd0 || ifb.stall_cnt !== 4'd0 || ifa.mem_err !== 1'b0) begin
            n_bad++; $display("FAIL rmw_regs: got %0d %0d err=%b want 0 0 0", ifa.stall_cnt, ifb.stall_cnt, ifa.mem_err);
        end
        mem_req = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        settle();
        n_vec++; if (ctrl_a !== V_NONE) begin n_bad++; $display("FAIL rmw_run: got %b want %b", ctrl_a, V_NONE); end
        advance(); settle();
        n_vec++; if (ifa.mem_err !== 1'b0) begin n_bad++; $display("FAIL rmw_err: got %b want 0", ifa.mem_err); end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 20; i++) begin settle(); advance(); end
        mem_req = 0;
        settle();
        n_vec++; if (ifb.stall_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_b: got %0d want 15", ifb.stall_cnt); end
        n_vec++; if (ifa.stall_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_a: got %0d want 20", ifa.stall_cnt); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            ex_memread = ($urandom_range(0, 2) == 0);
            id_fence = ($urandom_range(0, 7) == 0);
            ex_taken = ($urandom_range(0, 5) == 0);
            ex_target = $urandom;
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            settle();
            n_vec++; if (ctrl_a !== exp_ctrl) begin n_bad++; $display("FAIL rnd_ctrl@%0d: got %b want %b", i, ctrl_a, exp_ctrl); end
            n_vec++; if (ifa.redirect_pc !== ex_target) begin n_bad++; $display("FAIL rnd_pc@%0d: got %h want %h", i, ifa.redirect_pc, ex_target); end
            n_vec++; if (ifa.mem_err !== m_err) begin n_bad++; $display("FAIL rnd_err@%0d: got %b want %b", i, ifa.mem_err, m_err); end
            n_vec++; if (int'(ifa.stall_cnt) != m_scnt) begin n_bad++; $display("FAIL rnd_scnt@%0d: got %0d want %0d", i, ifa.stall_cnt, m_scnt); end
            n_vec++; if (int'(ifa.flush_cnt) != m_fcnt) begin n_bad++; $display("FAIL rnd_fcnt@%0d: got %0d want %0d", i, ifa.flush_cnt, m_fcnt); end
            advance();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_fence();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
